// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top (push+pop), sticky ovf/unf and registered read port.
// Optional STACK_PEEK_EN macro adds a registered random-depth peek port.
module param_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
`ifdef STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_vld
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] top_data;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign top_idx  = AW'(count_q - CW'(1));
  assign wr_idx   = AW'(count_q);
  assign top_data = mem_q[top_idx];

  // Next-state: pop outranks tos; push+pop is handled as a single replace-top/bypass op.
  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = ovf_q & ~clr_err;
    unf_d      = unf_q & ~clr_err;

    if (push && pop) begin
      dout_vld_d = 1'b1;
      if (!is_empty) begin
        dout_d          = top_data;
        mem_d[top_idx]  = din;
      end else begin
        dout_d = din;
      end
    end else begin
      if (pop || tos) begin
        if (!is_empty) begin
          dout_d     = top_data;
          dout_vld_d = 1'b1;
          if (pop) count_d = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      if (push) begin
        if (!is_full) begin
          mem_d[wr_idx] = din;
          count_d       = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

`ifdef STACK_PEEK_EN
  logic [WIDTH-1:0] peek_data_q, peek_data_d;
  logic             peek_vld_q, peek_vld_d;

  // Peek samples the pre-update stack; depth 0 is the current top.
  always_comb begin
    peek_vld_d  = (CW'(peek_idx) < count_q);
    peek_data_d = '0;
    if (peek_vld_d) peek_data_d = mem_q[AW'(count_q - CW'(1) - CW'(peek_idx))];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peek_data_q <= '0;
      peek_vld_q  <= 1'b0;
    end else begin
      peek_data_q <= peek_data_d;
      peek_vld_q  <= peek_vld_d;
    end
  end

  assign peek_data = peek_data_q;
  assign peek_vld  = peek_vld_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios plus random traffic against a queue model.
module tb_param_stack;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             push, pop, tos, clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_vld, full, empty, ovf, unf;
  logic [CW-1:0]    count;
`ifdef STACK_PEEK_EN
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_vld;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld, m_ovf, m_unf;
  logic [WIDTH-1:0] m_pk_data;
  logic             m_pk_vld;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .tos(tos),
    .clr_err(clr_err), .dout(dout), .dout_vld(dout_vld), .full(full),
    .empty(empty), .count(count), .ovf(ovf), .unf(unf)
`ifdef STACK_PEEK_EN
    , .peek_idx(peek_idx), .peek_data(peek_data), .peek_vld(peek_vld)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_pk_data = '0; m_pk_vld = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic do_cycle(input logic pu, input logic po, input logic to,
                          input logic [WIDTH-1:0] d, input logic ce, input int pk);
    push = pu; pop = po; tos = to; din = d; clr_err = ce;
`ifdef STACK_PEEK_EN
    peek_idx = AW'(pk);
`endif
    m_vld = 1'b0;
    if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (pk < mq.size()) begin m_pk_data = mq[mq.size() - 1 - pk]; m_pk_vld = 1'b1; end
    else begin m_pk_data = '0; m_pk_vld = 1'b0; end
    if (pu && po) begin
      m_vld = 1'b1;
      if (mq.size() > 0) begin m_dout = mq[mq.size() - 1]; mq[mq.size() - 1] = d; end
      else m_dout = d;
    end else begin
      if (po || to) begin
        if (mq.size() > 0) begin
          m_dout = mq[mq.size() - 1]; m_vld = 1'b1;
          if (po) void'(mq.pop_back());
        end else m_unf = 1'b1;
      end
      if (pu) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    push = 0; pop = 0; tos = 0; clr_err = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; #2; rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; push = 0; pop = 0; tos = 0; clr_err = 0; din = '0;
`ifdef STACK_PEEK_EN
    peek_idx = '0;
`endif
    model_reset();
    #12;
    n_checks++; if (count !== 0 || empty !== 1 || full !== 0 || dout !== 0 || dout_vld !== 0 || ovf !== 0 || unf !== 0) begin
      n_errors++; $display("FAIL reset_init: count=%0d empty=%b dout=%h vld=%b ovf=%b unf=%b, expected 0 1 00 0 0 0", count, empty, dout, dout_vld, ovf, unf); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_cycle(1, 0, 0, 8'h5A, 0, 0);
    do_cycle(1, 0, 0, 8'h6B, 0, 0);
    do_cycle(0, 0, 1, 8'h00, 0, 0);
    do_cycle(1, 0, 0, 8'h00, 0, 0);
    // async reset mid-run, away from the clock edge
    rst = 1'b0; #2;
    model_reset();
    n_checks++; if (count !== 0 || empty !== 1 || dout !== 0 || ovf !== 0 || unf !== 0 || dout_vld !== 0) begin
      n_errors++; $display("FAIL reset_midrun: count=%0d empty=%b dout=%h ovf=%b unf=%b vld=%b, expected 0 1 00 0 0 0", count, empty, dout, ovf, unf, dout_vld); end
    rst = 1'b1;
    do_cycle(0, 1, 0, 8'h00, 0, 0);
    n_checks++; if (unf !== 1 || dout_vld !== 0 || dout !== 0) begin
      n_errors++; $display("FAIL reset_pop_empty: unf=%b vld=%b dout=%h, expected 1 0 00", unf, dout_vld, dout); end
  endtask

  task automatic test_push_pop();
    logic [WIDTH-1:0] exp_v [3];
    apply_reset();
    do_cycle(1, 0, 0, 8'h11, 0, 0);
    do_cycle(1, 0, 0, 8'h22, 0, 0);
    do_cycle(1, 0, 0, 8'h33, 0, 0);
    n_checks++; if (count !== 3) begin n_errors++; $display("FAIL pp_count3: count=%0d, expected 3", count); end
    exp_v[0] = 8'h33; exp_v[1] = 8'h22; exp_v[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 1, 0, 8'h00, 0, 0);
      n_checks++; if (dout !== exp_v[i] || dout_vld !== 1 || count !== CW'(2 - i)) begin
        n_errors++; $display("FAIL pp_pop%0d: dout=%h vld=%b count=%0d, expected %h 1 %0d", i, dout, dout_vld, count, exp_v[i], 2 - i); end
    end
    n_checks++; if (empty !== 1) begin n_errors++; $display("FAIL pp_empty: empty=%b, expected 1", empty); end
    do_cycle(0, 0, 0, 8'h00, 0, 0);
    n_checks++; if (dout_vld !== 0 || dout !== 8'h11) begin n_errors++; $display("FAIL pp_idle: vld=%b dout=%h, expected 0 11", dout_vld, dout); end
  endtask

  task automatic test_fill_ovf();
    apply_reset();
    for (int i = 0; i < int'(DEPTH); i++) do_cycle(1, 0, 0, WIDTH'(i), 0, 0);
    n_checks++; if (full !== 1 || count !== CW'(DEPTH) || ovf !== 0) begin
      n_errors++; $display("FAIL fill_full: full=%b count=%0d ovf=%b, expected 1 %0d 0", full, count, ovf, DEPTH); end
    do_cycle(1, 0, 0, 8'hAA, 0, 0);
    n_checks++; if (full !== 1 || count !== CW'(DEPTH) || ovf !== 1) begin
      n_errors++; $display("FAIL fill_ovf: full=%b count=%0d ovf=%b, expected 1 %0d 1", full, count, ovf, DEPTH); end
    do_cycle(0, 1, 0, 8'h00, 0, 0);
    n_checks++; if (dout !== 8'h1F || dout_vld !== 1 || ovf !== 1) begin
      n_errors++; $display("FAIL fill_pop: dout=%h vld=%b ovf=%b, expected 1f 1 1", dout, dout_vld, ovf); end
    do_cycle(0, 0, 0, 8'h00, 1, 0);
    n_checks++; if (ovf !== 0) begin n_errors++; $display("FAIL fill_clr: ovf=%b, expected 0", ovf); end
    // error event in the same cycle as clr_err keeps the flag set
    do_cycle(1, 0, 0, 8'h01, 0, 0);
    do_cycle(1, 0, 0, 8'h02, 1, 0);
    n_checks++; if (ovf !== 1 || count !== CW'(DEPTH)) begin
      n_errors++; $display("FAIL clr_vs_event: ovf=%b count=%0d, expected 1 %0d", ovf, count, DEPTH); end
    do_cycle(1, 1, 0, 8'h77, 0, 0);
    n_checks++; if (dout !== 8'h01 || ovf !== 1 || count !== CW'(DEPTH) || dout_vld !== 1) begin
      n_errors++; $display("FAIL swap_full: dout=%h ovf=%b count=%0d vld=%b, expected 01 1 %0d 1", dout, ovf, count, dout_vld, DEPTH); end
  endtask

  task automatic test_swap();
    apply_reset();
    do_cycle(1, 0, 0, 8'h05, 0, 0);
    do_cycle(1, 1, 0, 8'h09, 0, 0);
    n_checks++; if (dout !== 8'h05 || dout_vld !== 1 || count !== 1) begin
      n_errors++; $display("FAIL swap: dout=%h vld=%b count=%0d, expected 05 1 1", dout, dout_vld, count); end
    do_cycle(0, 0, 1, 8'h00, 0, 0);
    n_checks++; if (dout !== 8'h09 || dout_vld !== 1 || count !== 1) begin
      n_errors++; $display("FAIL swap_tos: dout=%h vld=%b count=%0d, expected 09 1 1", dout, dout_vld, count); end
    do_cycle(0, 1, 0, 8'h00, 0, 0);
    do_cycle(1, 1, 0, 8'h7E, 0, 0);
    n_checks++; if (dout !== 8'h7E || dout_vld !== 1 || count !== 0 || unf !== 0 || empty !== 1) begin
      n_errors++; $display("FAIL bypass: dout=%h vld=%b count=%0d unf=%b empty=%b, expected 7e 1 0 0 1", dout, dout_vld, count, unf, empty); end
  endtask

  task automatic test_tos();
    apply_reset();
    do_cycle(1, 0, 0, 8'h40, 0, 0);
    do_cycle(1, 0, 0, 8'h41, 0, 0);
    do_cycle(0, 0, 1, 8'h00, 0, 0);
    n_checks++; if (dout !== 8'h41 || dout_vld !== 1 || count !== 2) begin
      n_errors++; $display("FAIL tos: dout=%h vld=%b count=%0d, expected 41 1 2", dout, dout_vld, count); end
    do_cycle(0, 1, 1, 8'h00, 0, 0);
    n_checks++; if (dout !== 8'h41 || dout_vld !== 1 || count !== 1) begin
      n_errors++; $display("FAIL pop_tos: dout=%h vld=%b count=%0d, expected 41 1 1", dout, dout_vld, count); end
    do_cycle(1, 0, 1, 8'h55, 0, 0);
    n_checks++; if (dout !== 8'h40 || dout_vld !== 1 || count !== 2) begin
      n_errors++; $display("FAIL push_tos: dout=%h vld=%b count=%0d, expected 40 1 2", dout, dout_vld, count); end
    do_cycle(0, 1, 0, 8'h00, 0, 0);
    do_cycle(0, 1, 0, 8'h00, 0, 0);
    do_cycle(1, 0, 1, 8'h66, 0, 0);
    n_checks++; if (unf !== 1 || dout_vld !== 0 || count !== 1) begin
      n_errors++; $display("FAIL push_tos_empty: unf=%b vld=%b count=%0d, expected 1 0 1", unf, dout_vld, count); end
  endtask

  task automatic test_random();
    logic pu, po, to, ce;
    int pk;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      // alternate push-heavy and pop-heavy phases so both limits are reached
      if ((i / 100) % 2 == 0) begin pu = ($urandom_range(0, 99) < 75); po = ($urandom_range(0, 99) < 20); end
      else begin pu = ($urandom_range(0, 99) < 20); po = ($urandom_range(0, 99) < 75); end
      to = ($urandom_range(0, 99) < 25);
      ce = ($urandom_range(0, 99) < 8);
      pk = int'($urandom_range(0, DEPTH - 1));
      do_cycle(pu, po, to, WIDTH'($urandom), ce, pk);
      n_checks++; if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        n_errors++; $display("FAIL rnd_count[%0d]: count=%0d full=%b empty=%b, expected %0d", i, count, full, empty, mq.size()); end
      n_checks++; if (dout !== m_dout || dout_vld !== m_vld) begin
        n_errors++; $display("FAIL rnd_dout[%0d]: dout=%h vld=%b, expected %h %b", i, dout, dout_vld, m_dout, m_vld); end
      n_checks++; if (ovf !== m_ovf || unf !== m_unf) begin
        n_errors++; $display("FAIL rnd_err[%0d]: ovf=%b unf=%b, expected %b %b", i, ovf, unf, m_ovf, m_unf); end
`ifdef STACK_PEEK_EN
      n_checks++; if (peek_data !== m_pk_data || peek_vld !== m_pk_vld) begin
        n_errors++; $display("FAIL rnd_peek[%0d]: data=%h vld=%b, expected %h %b", i, peek_data, peek_vld, m_pk_data, m_pk_vld); end
`endif
    end
  endtask

`ifdef STACK_PEEK_EN
  task automatic test_peek();
    apply_reset();
    do_cycle(1, 0, 0, 8'h01, 0, 0);
    do_cycle(1, 0, 0, 8'h02, 0, 0);
    do_cycle(1, 0, 0, 8'h03, 0, 0);
    do_cycle(0, 0, 0, 8'h00, 0, 2);
    n_checks++; if (peek_data !== 8'h01 || peek_vld !== 1) begin
      n_errors++; $display("FAIL peek_2: data=%h vld=%b, expected 01 1", peek_data, peek_vld); end
    do_cycle(0, 0, 0, 8'h00, 0, 3);
    n_checks++; if (peek_data !== 8'h00 || peek_vld !== 0) begin
      n_errors++; $display("FAIL peek_3: data=%h vld=%b, expected 00 0", peek_data, peek_vld); end
  endtask
`endif

  initial begin
    test_reset();
    test_push_pop();
    test_fill_ovf();
    test_swap();
    test_tos();
`ifdef STACK_PEEK_EN
    test_peek();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
